// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment driver: per-digit 5-bit code registers, a free-running
// slot prescaler with HOLD, leading dead-time per slot, and registered outputs.
module seg_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int DEAD_CYC   = 1,
    parameter int IDX_W      = 3
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  WR_EN,
    input  logic [IDX_W-1:0]      WR_ADDR,
    input  logic [4:0]            WR_DATA,
    input  logic                  HOLD,
    output logic [NUM_DIGITS-1:0] SEG_COM,
    output logic [6:0]            SEG_DATA,
    output logic [IDX_W-1:0]      SCAN_IDX
);

    localparam int                PRE_W    = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]      pre_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [4:0]            code_arr [NUM_DIGITS];
    logic [4:0]            cur_code;
    logic                  dead;
    logic [NUM_DIGITS-1:0] com_next;
    logic [NUM_DIGITS-1:0] seg_com_reg;
    logic [6:0]            seg_data_reg;

    function automatic logic [6:0] decode(input logic [3:0] hex);
        case (hex)
            4'h0:    decode = 7'b1111110;
            4'h1:    decode = 7'b0110000;
            4'h2:    decode = 7'b1101101;
            4'h3:    decode = 7'b1111001;
            4'h4:    decode = 7'b0110011;
            4'h5:    decode = 7'b1011011;
            4'h6:    decode = 7'b1011111;
            4'h7:    decode = 7'b1110000;
            4'h8:    decode = 7'b1111111;
            4'h9:    decode = 7'b1111011;
            4'hA:    decode = 7'b1110111;
            4'hB:    decode = 7'b0011111;
            4'hC:    decode = 7'b1001110;
            4'hD:    decode = 7'b0111101;
            4'hE:    decode = 7'b1001111;
            default: decode = 7'b1000111;
        endcase
    endfunction

    // Addresses beyond the last digit match no register and are dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [4:0] code_reg;

            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    code_reg <= 5'b1_0000;
                end else if (WR_EN && (WR_ADDR == IDX_W'(gi))) begin
                    code_reg <= WR_DATA;
                end
            end

            assign code_arr[gi] = code_reg;
            // Digit d owns common bit NUM_DIGITS-1-d.
            assign com_next[gi] = dead || (idx_reg != IDX_W'(NUM_DIGITS - 1 - gi));
        end

        if (DEAD_CYC == 0) begin : g_no_dead
            assign dead = 1'b0;
        end else begin : g_dead
            assign dead = (pre_reg < PRE_W'(DEAD_CYC));
        end
    endgenerate

    assign cur_code = code_arr[idx_reg];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pre_reg <= '0;
            idx_reg <= '0;
        end else if (!HOLD) begin
            if (pre_reg == PRE_LAST) begin
                pre_reg <= '0;
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end else begin
                pre_reg <= pre_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            seg_com_reg  <= '1;
            seg_data_reg <= '0;
        end else begin
            seg_com_reg  <= com_next;
            seg_data_reg <= cur_code[4] ? 7'b0000000 : decode(cur_code[3:0]);
        end
    end

    assign SEG_COM  = seg_com_reg;
    assign SEG_DATA = seg_data_reg;
    assign SCAN_IDX = idx_reg;

endmodule
